// File: rtl/spi_slave_pkg.sv
// Shared types and constants for the SPI slave responder and its shift register.
// No logic of its own; no latency, no flow control.
package spi_slave_pkg;

   typedef enum logic {
      IDLE  = 1'b0,
      SHIFT = 1'b1
   } state_t;

   localparam int CHAR_LEN_MAX = 128;

   localparam logic [CHAR_LEN_MAX-1:0] TX_IDLE_DEFAULT = '0;

   // Bit counter width: enough to count 0..CHAR_LEN-1, never narrower than 1.
   function automatic int cnt_width(input int char_len);
      return (char_len < 2) ? 1 : $clog2(char_len);
   endfunction

endpackage

// File: rtl/spi_slave_shreg.sv
// Shared RX/TX shift register: serial-in/serial-out in either bit order, parallel load wins over shift.
// Updates on the clock edge after load/shift; no backpressure.
module spi_slave_shreg #(
   parameter int                  CHAR_LEN  = 32,
   parameter bit                  LSB_FIRST = 1'b0,
   parameter logic [CHAR_LEN-1:0] RST_VAL   = '0
) (
   input  logic                spi_clk,
   input  logic                spi_rst_n,
   input  logic                load,
   input  logic [CHAR_LEN-1:0] load_dat,
   input  logic                shift,
   input  logic                ser_in,
   output logic                ser_out,
   output logic [CHAR_LEN-1:0] par_shift
);

   logic [CHAR_LEN-1:0] sreg;

   // par_shift is the register value after the current shift, i.e. the
   // complete received word on the cycle that takes in the last bit.
   generate
      if (LSB_FIRST) begin : g_lsb
         assign par_shift = {ser_in, sreg[CHAR_LEN-1:1]};
         assign ser_out   = sreg[0];
      end else begin : g_msb
         assign par_shift = {sreg[CHAR_LEN-2:0], ser_in};
         assign ser_out   = sreg[CHAR_LEN-1];
      end
   endgenerate

   always_ff @(posedge spi_clk or negedge spi_rst_n) begin
      if (!spi_rst_n) begin
         sreg <= RST_VAL;
      end else if (load) begin
         sreg <= load_dat;
      end else if (shift) begin
         sreg <= par_shift;
      end
   end

endmodule

// File: rtl/spi_slave_responder.sv
// SPI slave clocked by the serial clock: one CHAR_LEN character in on MOSI / out on MISO per transfer.
// rx_valid on the last-bit posedge, held until rx_ready; one-entry TX holding register, underrun/overrun pulses.
`ifndef SPI_SS_NB
`define SPI_SS_NB 8
`endif

module spi_slave_responder
   import spi_slave_pkg::*;
#(
   parameter int                  SS_NB     = `SPI_SS_NB,
   parameter int                  SS_IDX    = 0,
   parameter int                  CHAR_LEN  = 32,
   parameter bit                  LSB_FIRST = 1'b0,
   parameter logic [CHAR_LEN-1:0] TX_IDLE   = CHAR_LEN'(TX_IDLE_DEFAULT)
) (
   input  logic                spi_clk,
   input  logic                spi_rst_n,
   input  logic [SS_NB-1:0]    ss_pad_i,
   input  logic                mosi_pad_i,
   output logic                miso_pad_o,
   input  logic [CHAR_LEN-1:0] tx_data,
   input  logic                tx_valid,
   output logic                tx_ready,
   output logic [CHAR_LEN-1:0] rx_data,
   output logic                rx_valid,
   input  logic                rx_ready,
   output logic                tx_underrun,
   output logic                rx_overrun,
   output logic                xfer_abort
);

   localparam int            CW   = cnt_width(CHAR_LEN);
   localparam logic [CW-1:0] LAST = CW'(CHAR_LEN - 1);

   state_t              state;
   logic [CW-1:0]       bit_cnt;
   logic [CHAR_LEN-1:0] hold_dat;
   logic                hold_full;
   logic                sh_full;
   logic                out_en;
   logic                sel;
   logic                ss_unused;
   logic                char_start;
   logic                last_bit;
   logic                abort;
   logic                refill;
   logic                sh_load;
   logic [CHAR_LEN-1:0] sh_load_dat;
   logic [CHAR_LEN-1:0] sh_next;
   logic                ser_out;

   assign sel       = ~ss_pad_i[SS_IDX];
   assign ss_unused = &ss_pad_i;

   assign char_start = sel && (bit_cnt == '0);
   assign last_bit   = sel && (state == SHIFT) && (bit_cnt == LAST);
   assign abort      = !sel && (state == SHIFT) && (bit_cnt != '0);
   // Idle refill only while deselected, so the first bit is stable before the first edge.
   assign refill     = (state == IDLE) && !sel && !sh_full && hold_full;

   assign sh_load     = last_bit | abort | refill;
   assign sh_load_dat = hold_full ? hold_dat : TX_IDLE;

   assign tx_ready   = ~hold_full;
   assign miso_pad_o = sel & out_en & ser_out;

   spi_slave_shreg #(
      .CHAR_LEN  (CHAR_LEN),
      .LSB_FIRST (LSB_FIRST),
      .RST_VAL   (TX_IDLE)
   ) u_shreg (
      .spi_clk   (spi_clk),
      .spi_rst_n (spi_rst_n),
      .load      (sh_load),
      .load_dat  (sh_load_dat),
      .shift     (sel),
      .ser_in    (mosi_pad_i),
      .ser_out   (ser_out),
      .par_shift (sh_next)
   );

   always_ff @(posedge spi_clk or negedge spi_rst_n) begin
      if (!spi_rst_n) begin
         state       <= IDLE;
         bit_cnt     <= '0;
         tx_underrun <= 1'b0;
         xfer_abort  <= 1'b0;
         out_en      <= 1'b0;
      end else begin
         out_en      <= 1'b1;
         // A character that begins from the idle pattern is the underrun event.
         tx_underrun <= char_start & ~sh_full;
         xfer_abort  <= abort;
         if (sel) begin
            state   <= SHIFT;
            bit_cnt <= last_bit ? '0 : bit_cnt + CW'(1);
         end else begin
            state   <= IDLE;
            bit_cnt <= '0;
         end
      end
   end

   always_ff @(posedge spi_clk or negedge spi_rst_n) begin
      if (!spi_rst_n) begin
         hold_dat  <= '0;
         hold_full <= 1'b0;
         sh_full   <= 1'b0;
      end else begin
         if (sh_load) begin
            sh_full <= hold_full;
         end
         if (sh_load && hold_full) begin
            hold_full <= 1'b0;
         end else if (tx_valid && tx_ready) begin
            hold_full <= 1'b1;
            hold_dat  <= tx_data;
         end
      end
   end

   always_ff @(posedge spi_clk or negedge spi_rst_n) begin
      if (!spi_rst_n) begin
         rx_data    <= '0;
         rx_valid   <= 1'b0;
         rx_overrun <= 1'b0;
      end else begin
         rx_overrun <= 1'b0;
         if (last_bit && rx_valid && !rx_ready) begin
            rx_overrun <= 1'b1;
         end else if (last_bit) begin
            rx_data  <= sh_next;
            rx_valid <= 1'b1;
         end else if (rx_ready) begin
            rx_valid <= 1'b0;
         end
      end
   end

endmodule
